// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port DataMemory.
// master: arbiter view (drives gnt/rvalid/rdata and the memory strobes).
// slave : requester/memory view (drives req/we/addr/wdata and mem_rdata).
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req, core_we, core_gnt, core_rvalid;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, owner;

  modport master (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-requester (core / debug) arbiter in front of the single-port DataMemory.
// One access in flight: IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE.
// Optional feature macro ARB_ROUND_ROBIN_EN: on a tie the port that did not own
// the previous access wins; otherwise the core always wins a tie.
module data_memory_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1   // 1..4 cycles strobe -> mem_rdata
) (
  input  logic                  clock,
  input  logic                  reset,   // async, active low
  data_memory_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e            state_q;
  logic              we_q, owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, core_rdata_q, dbg_rdata_q;
  logic [2:0]        cnt_q;
  logic              mem_read_q, mem_write_q, core_rvalid_q, dbg_rvalid_q;

  logic              idle, any_req, pick_dbg, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, resp_data;

  // Winner selection and the request fields to latch at the grant edge
  always_comb begin
    idle    = (state_q == IDLE);
    any_req = bus.core_req | bus.dbg_req;
`ifdef ARB_ROUND_ROBIN_EN
    pick_dbg = bus.dbg_req & (~bus.core_req | ~owner_q);
`else
    pick_dbg = bus.dbg_req & ~bus.core_req;
`endif
    we_d      = pick_dbg ? bus.dbg_we    : bus.core_we;
    addr_d    = pick_dbg ? bus.dbg_addr  : bus.core_addr;
    wdata_d   = pick_dbg ? bus.dbg_wdata : bus.core_wdata;
    resp_data = we_q ? '0 : bus.mem_rdata;
  end

  // Grants are combinational in IDLE; rdata is live during the response cycle
  // and held from the capture register afterwards.
  assign bus.core_gnt    = idle & bus.core_req & ~pick_dbg;
  assign bus.dbg_gnt     = idle & pick_dbg;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;
  assign bus.core_rdata  = core_rvalid_q ? resp_data : core_rdata_q;
  assign bus.dbg_rdata   = dbg_rvalid_q  ? resp_data : dbg_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = ~idle;
  assign bus.owner       = owner_q;

  // Access sequencer with registered strobes and response pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      owner_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          we_q        <= we_d;
          addr_q      <= addr_d;
          wdata_q     <= wdata_d;
          owner_q     <= pick_dbg;
          mem_read_q  <= ~we_d;
          mem_write_q <= we_d;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          cnt_q <= 3'(MEM_LATENCY - 1);
          if (MEM_LATENCY == 1) begin
            state_q       <= RESP;
            core_rvalid_q <= ~owner_q;
            dbg_rvalid_q  <= owner_q;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q       <= RESP;
            core_rvalid_q <= ~owner_q;
            dbg_rvalid_q  <= owner_q;
          end
        end
        RESP: begin
          if (owner_q) dbg_rdata_q  <= resp_data;
          else         core_rdata_q <= resp_data;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: two arbiters (MEM_LATENCY 1 and 3) driven from one initial block.
module tb_data_memory_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .bus(b1.master));
  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u3 (
    .clock(clock), .reset(reset), .bus(b3.master));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    b1.core_req = 0; b1.core_we = 0; b1.core_addr = '0; b1.core_wdata = '0;
    b1.dbg_req  = 0; b1.dbg_we  = 0; b1.dbg_addr  = '0; b1.dbg_wdata  = '0;
    b3.core_req = 0; b3.core_we = 0; b3.core_addr = '0; b3.core_wdata = '0;
    b3.dbg_req  = 0; b3.dbg_we  = 0; b3.dbg_addr  = '0; b3.dbg_wdata  = '0;
    b1.mem_rdata = 32'hDEADBEEF;
    b3.mem_rdata = 32'hAAAA5555;

    // reset state
    #1;
    chk("rst_outs1", {b1.busy, b1.mem_read, b1.mem_write, b1.core_gnt, b1.dbg_gnt,
                      b1.core_rvalid, b1.dbg_rvalid, b1.owner}, 0);
    chk("rst_rdata1", {b1.core_rdata, b1.dbg_rdata}, 0);
    chk("rst_outs3", {b3.busy, b3.mem_read, b3.mem_write, b3.owner}, 0);
    step();
    step();
    reset = 1'b1;

    // 1: idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      #1;
      chk("idle_outs", {b1.busy, b1.mem_read, b1.mem_write, b1.core_gnt, b1.dbg_gnt,
                        b1.core_rvalid, b1.dbg_rvalid}, 0);
    end

    // 2: core load, latency 1
    step();
    b1.core_req = 1; b1.core_we = 0; b1.core_addr = 32'h10; b1.core_wdata = 32'h55;
    #1;
    chk("t2_gnt", {b1.core_gnt, b1.dbg_gnt, b1.busy}, 3'b100);
    step();
    b1.core_req = 0; b1.core_addr = 32'hFFFF;
    #1;
    chk("t2_strobe", {b1.mem_read, b1.mem_write, b1.core_gnt, b1.busy}, 4'b1001);
    chk("t2_maddr", b1.mem_addr, 32'h10);
    step();
    #1;
    chk("t2_rvalid", {b1.core_rvalid, b1.dbg_rvalid, b1.mem_read}, 3'b100);
    chk("t2_rdata", b1.core_rdata, 32'hDEADBEEF);
    step();
    #1;
    chk("t2_after", {b1.core_rvalid, b1.busy}, 0);
    chk("t2_hold", b1.core_rdata, 32'hDEADBEEF);

    // 3: dbg store, latency 3
    step();
    b3.dbg_req = 1; b3.dbg_we = 1; b3.dbg_addr = 32'h20; b3.dbg_wdata = 32'h12345678;
    #1;
    chk("t3_gnt", {b3.dbg_gnt, b3.core_gnt}, 2'b10);
    step();
    b3.dbg_req = 0; b3.dbg_wdata = '1;
    #1;
    chk("t3_strobe", {b3.mem_write, b3.mem_read, b3.owner}, 3'b101);
    chk("t3_mem", {b3.mem_addr, b3.mem_wdata}, {32'h20, 32'h12345678});
    step();
    #1;
    chk("t3_wait", {b3.mem_write, b3.mem_read, b3.busy, b3.dbg_rvalid}, 4'b0010);
    chk("t3_waddr", b3.mem_addr, 32'h20);
    step();
    #1;
    chk("t3_wait2", {b3.dbg_rvalid, b3.core_rvalid}, 0);
    step();
    #1;
    chk("t3_rvalid", {b3.dbg_rvalid, b3.core_rvalid}, 2'b10);
    chk("t3_rdata", b3.dbg_rdata, 0);
    step();
    #1;
    chk("t3_after", {b3.dbg_rvalid, b3.core_rvalid, b3.busy}, 0);
    chk("t3_core_rd", b3.core_rdata, 0);

    // 4: both requesters held on the latency-1 arbiter
    step();
    rst_pulse();
    b1.core_req = 1; b1.core_we = 0; b1.core_addr = 32'h100;
    b1.dbg_req  = 1; b1.dbg_we  = 0; b1.dbg_addr  = 32'h200;
    for (int k = 0; k < 9; k++) begin
      logic dbg_exp, core_exp;
      if (k > 0) step();
      #1;
      dbg_exp = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      dbg_exp = (k % 3 == 0) && ((k / 3) % 2 == 0);
`endif
      core_exp = (k % 3 == 0) && !dbg_exp;
      chk("t4_gnts", {b1.core_gnt, b1.dbg_gnt}, {core_exp, dbg_exp});
      chk("t4_rv_excl", b1.core_rvalid & b1.dbg_rvalid, 0);
    end
    b1.core_req = 0; b1.dbg_req = 0;

    // 5: reset during WAIT on the latency-3 arbiter
    step();
    rst_pulse();
    b3.core_req = 1; b3.core_we = 0; b3.core_addr = 32'h40;
    #1;
    chk("t5_gnt", b3.core_gnt, 1);
    step();
    #1;
    chk("t5_strobe", b3.mem_read, 1);
    step();
    #1;
    chk("t5_wait", b3.busy, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_now", {b3.busy, b3.mem_read, b3.mem_write, b3.core_rvalid, b3.dbg_rvalid}, 0);
    step();
    step();
    #1;
    chk("t5_no_rv", {b3.core_rvalid, b3.dbg_rvalid, b3.busy}, 0);
    reset = 1'b1;
    #1;
    chk("t5_regnt", b3.core_gnt, 1);
    step();
    b3.core_req = 0;
    #1;
    chk("t5_restrobe", {b3.mem_read, b3.mem_addr}, {1'b1, 32'h40});
    step();
    step();
    step();
    #1;
    chk("t5_rvalid", {b3.core_rvalid, b3.dbg_rvalid}, 2'b10);
    chk("t5_rdata", b3.core_rdata, 32'hAAAA5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
